// File: rtl/adder_share_arb_pkg.sv
// Shared types and default sizing for the adder_share_arb block and its datapath.
package adder_share_arb_pkg;
  localparam int DEF_WIDTH       = 16;
  localparam int DEF_APPROX_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/adder_share_arb_adder.sv
// Ripple-carry adder: the low APPROX_BITS cells are approximate, the rest exact full adders.
module approx_rc_adder
  import adder_share_arb_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);
  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i < APPROX_BITS) begin : g_apx
      // Carry is simply forwarded from a, breaking the carry chain in the low bits.
      assign sum[i]   = (~a[i] & (b[i] | c[i])) | (a[i] & b[i] & c[i]);
      assign c[i+1]   = a[i];
    end else begin : g_exact
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign sum[WIDTH] = c[WIDTH];
endmodule

// File: rtl/adder_share_arb.sv
// Two requesters share one approximate adder through a round-robin arbiter.
// Define ADDER_ERR_STAT_EN to add squared-error accumulation (err_acc) and an op counter (op_cnt).
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_id,
`ifdef ADDER_ERR_STAT_EN
  output logic [39:0]      err_acc,
  output logic [15:0]      op_cnt,
`endif
  output state_t           dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // readies are only raised in IDLE, out_valid is held with stable data until out_ready.
  state_t           state;
  logic             ptr;
  logic             id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   apx_sum;
  logic             any_valid, win_id, idle_ok, accept;

  assign any_valid  = req0_valid | req1_valid;
  assign win_id     = (req0_valid & req1_valid) ? ptr : req1_valid;
  assign idle_ok    = (state == IDLE) & ~rst;
  assign accept     = idle_ok & any_valid;
  assign req0_ready = accept & ~win_id;
  assign req1_ready = accept & win_id;
  assign dbg_state  = state;

  approx_rc_adder #(
    .WIDTH      (WIDTH),
    .APPROX_BITS(APPROX_BITS)
  ) u_adder (
    .a  (a_q),
    .b  (b_q),
    .sum(apx_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      id_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= win_id ? req1_a : req0_a;
            b_q   <= win_id ? req1_b : req0_b;
            id_q  <= win_id;
            ptr   <= ~win_id;
            state <= CALC;
          end
        end
        CALC: begin
          out_sum   <= apx_sum;
          out_id    <= id_q;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDER_ERR_STAT_EN
  localparam int SQW = 2 * (WIDTH + 1);
  localparam int SW  = (SQW > 40) ? SQW : 40;

  logic [WIDTH:0] exact_sum, abs_err;
  logic [SQW-1:0] sq_err;
  logic [SW:0]    acc_next;

  assign exact_sum = {1'b0, a_q} + {1'b0, b_q};
  assign abs_err   = (apx_sum >= exact_sum) ? (apx_sum - exact_sum) : (exact_sum - apx_sum);
  assign sq_err    = SQW'(abs_err) * SQW'(abs_err);
  assign acc_next  = (SW+1)'(err_acc) + (SW+1)'(sq_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_acc <= '0;
      op_cnt  <= '0;
    end else if (state == CALC) begin
      err_acc <= (|acc_next[SW:40]) ? '1 : acc_next[39:0];
      op_cnt  <= op_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: directed scenarios plus randomized transactions.
module tb_adder_share_arb;
  import adder_share_arb_pkg::*;

  localparam int W  = 16;
  localparam int AB = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         out_valid, out_ready, out_id;
  logic [W:0]   out_sum;
  state_t       dbg_state;
`ifdef ADDER_ERR_STAT_EN
  logic [39:0]  err_acc;
  logic [15:0]  op_cnt;
  longint       err_model;
  int           op_model;
`endif

  int           n_tests = 0;
  int           n_fail  = 0;
  logic         exp_ptr;
  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  adder_share_arb #(.WIDTH(W), .APPROX_BITS(AB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .req0_ready(req0_ready),
    .req1_ready(req1_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_id    (out_id),
`ifdef ADDER_ERR_STAT_EN
    .err_acc   (err_acc),
    .op_cnt    (op_cnt),
`endif
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Low bits follow the approximate-cell rules; the exact upper part is plain addition.
  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    logic       c;
    logic       x, y;
    logic [W:0] s;
    int unsigned hi;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < AB; i++) begin
      x = a[i];
      y = b[i];
      s[i] = (~x & (y | c)) | (x & y & c);
      c = x;
    end
    hi = (int'(a) >> AB) + (int'(b) >> AB) + int'(c);
    s = s | (W+1)'(hi << AB);
    return s;
  endfunction

  task automatic clear_models();
    exp_ptr = 1'b0;
    exp_q.delete();
`ifdef ADDER_ERR_STAT_EN
    err_model = 0;
    op_model  = 0;
`endif
  endtask

  // Called at a negedge with the DUT in IDLE; leaves the bench at the first IDLE negedge after the handshake.
  task automatic txn(input logic v0, input logic v1,
                     input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1,
                     input int stall);
    int           waits;
    logic         win;
    logic [W+1:0] exp_e;
    logic [W:0]   held_sum;
    logic         held_id;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    out_ready = 1'b0;
    #1;
    waits = 0;
    while (!((req0_valid & req0_ready) | (req1_valid & req1_ready)) && waits < 10) begin
      @(negedge clk); #1;
      waits++;
    end
    check("grant_latency", 64'(waits), 64'd0);
    if (waits >= 10) return;
    win = (v0 && v1) ? exp_ptr : v1;
    check("grant_id", 64'(req1_ready), 64'(win));
    check("ready_onehot", 64'(req0_ready & req1_ready), 64'd0);
    exp_ptr = ~win;
    exp_q.push_back({win, model_sum(win ? a1 : a0, win ? b1 : b0)});
`ifdef ADDER_ERR_STAT_EN
    begin
      longint d;
      d = longint'(model_sum(win ? a1 : a0, win ? b1 : b0)) - (longint'(win ? a1 : a0) + longint'(win ? b1 : b0));
      err_model = err_model + d * d;
      if (err_model > 64'hFF_FFFF_FFFF) err_model = 64'hFF_FFFF_FFFF;
      op_model = (op_model + 1) % 65536;
    end
`endif
    @(posedge clk); @(negedge clk);
    check("calc_state", 64'(dbg_state), 64'(CALC));
    check("calc_no_valid", 64'(out_valid), 64'd0);
    check("calc_readies", 64'({req0_ready, req1_ready}), 64'd0);
    @(negedge clk);
    check("hold_valid", 64'(out_valid), 64'd1);
    exp_e = exp_q.pop_front();
    check("out_sum", 64'(out_sum), 64'(exp_e[W:0]));
    check("out_id", 64'(out_id), 64'(exp_e[W+1]));
`ifdef ADDER_ERR_STAT_EN
    check("err_acc", 64'(err_acc), 64'(err_model));
    check("op_cnt", 64'(op_cnt), 64'(op_model));
`endif
    held_sum = out_sum;
    held_id  = out_id;
    for (int k = 0; k < stall; k++) begin
      req0_a = W'($urandom); req1_a = W'($urandom);
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_sum", 64'(out_sum), 64'(held_sum));
      check("stall_id", 64'(out_id), 64'(held_id));
      check("stall_readies", 64'({req0_ready, req1_ready}), 64'd0);
    end
    req0_a = a0; req1_a = a1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_state", 64'(dbg_state), 64'(IDLE));
  endtask

  initial begin
    logic       v0, v1;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    out_ready = 1'b0;
    clear_models();
    repeat (3) @(negedge clk);
    check("rst_readies", 64'({req0_ready, req1_ready}), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(out_sum), 64'd0);
    check("rst_id", 64'(out_id), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
`ifdef ADDER_ERR_STAT_EN
    check("rst_err_acc", 64'(err_acc), 64'd0);
    check("rst_op_cnt", 64'(op_cnt), 64'd0);
`endif
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_req_readies", 64'({req0_ready, req1_ready}), 64'd0);

    // Single requesters and carry into the MSB.
    txn(1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0);
    txn(1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 0);
    // Pointer is back at 0 here: both-valid grants should alternate 0,1,0,1.
    for (int t = 0; t < 4; t++)
      txn(1'b1, 1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0);
    // Long backpressure stall.
    txn(1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 10);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Abort a transaction with reset while it is in CALC; req0-only accept moves the pointer to 1.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h4321;
    #1;
    check("abort_grant", 64'(req0_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("abort_rst_readies", 64'({req0_ready, req1_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    clear_models();
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    check("abort_sum", 64'(out_sum), 64'd0);
    check("abort_id", 64'(out_id), 64'd0);
    for (int k = 0; k < 4; k++) begin
      check("abort_no_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    txn(1'b1, 1'b1, 16'h0003, 16'h0005, 16'h0007, 16'h0009, 0);

    // Randomized traffic with random backpressure.
    for (int t = 0; t < 40; t++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      txn(v0, v1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
          int'($urandom_range(0, 3)));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/adder_share_arb.md
ADDER_SHARE_ARB -- requirements
Module: adder_share_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand width in bits.
REQ-002 SHALL have parameter APPROX_BITS, default 8, meaning the number of LSB cells using the approximate cell; the upper WIDTH-APPROX_BITS cells are exact full adders.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports req0_valid, req1_valid, input, 1, requester operand valid.
REQ-006 SHALL have ports req0_ready, req1_ready, output, 1, requester accept.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, WIDTH, operands.
REQ-008 SHALL have port out_valid, input-side consumer ready out_ready; out_valid output 1, out_ready input 1.
REQ-009 SHALL have port out_sum, output, WIDTH+1, registered adder result.
REQ-010 SHALL have port out_id, output, 1, index of the requester owning out_sum.

Function
REQ-011 SHALL implement FSM IDLE -> CALC -> HOLD -> IDLE.
REQ-012 In IDLE, reqN_ready SHALL be 1 only for the arbitration winner; in CALC and HOLD both readies SHALL be 0.
REQ-013 Accept SHALL occur when reqN_valid and reqN_ready are both 1; operands and id are latched and the FSM goes to CALC.
REQ-014 Arbitration: single valid requester wins; both valid -> requester named by the round-robin pointer wins; the pointer then points to the loser.
REQ-015 Pointer SHALL update only on accept; no valid requester -> stay IDLE, pointer unchanged.
REQ-016 CALC SHALL last exactly one cycle, registering out_sum from the latched operands; out_valid rises in the next cycle (accept cycle N -> out_valid at N+2).
REQ-017 Approximate cell (bit i < APPROX_BITS, operands X, Y, carry-in Z): Cout = X; S = (~X & (Y | Z)) | (X & Y & Z).
REQ-018 Exact cell: S = X ^ Y ^ Z; Cout = majority(X, Y, Z). Carry-in to bit 0 = 0; carry-out of MSB = out_sum[WIDTH].
REQ-019 In HOLD, out_valid = 1; out_sum and out_id SHALL stay stable until out_ready = 1, then go to IDLE with out_valid = 0 the next cycle.
REQ-020 out_ready held 0 SHALL stall indefinitely; requests stay un-accepted and no data is lost or overwritten.
REQ-021 A request arriving during CALC or HOLD SHALL be arbitrated on the first IDLE cycle.

Reset
REQ-022 rst = 1 SHALL force IDLE, out_valid = 0, out_sum = 0, out_id = 0, pointer = 0, and both readies 0 in that cycle.
REQ-023 Reset asserted in CALC or HOLD SHALL drop the in-flight transaction; no out_valid follows it.

Configuration
REQ-024 With macro ADDER_ERR_STAT_EN defined, the block SHALL add outputs err_acc (40 bits) and op_cnt (16 bits).
REQ-025 With the macro defined, the block SHALL compute the exact WIDTH+1-bit sum in CALC and accumulate (approx - exact)^2 into err_acc, saturating at all-ones.
REQ-026 With the macro defined, op_cnt SHALL increment per completed CALC, wrap at 0xFFFF, and both counters SHALL clear on reset.
REQ-027 Without the macro, these ports and their logic SHALL be absent, with identical behaviour otherwise.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, CALC, HOLD) and the default WIDTH and APPROX_BITS constants.
REQ-029 The adder datapath SHALL be one combinational sub-module, approx_rc_adder, parameterised by WIDTH and APPROX_BITS.

Verification
REQ-030 Scenario: req0 only, a = 0x0001, b = 0x0000, out_ready = 1 -> out_sum = 0x00002, out_id = 0, out_valid exactly 2 cycles after accept; with ADDER_ERR_STAT_EN, err_acc = 1 and op_cnt = 1.
REQ-031 Scenario: req1, a = 0xFFFF, b = 0x0001 -> out_sum = 0x10000, out_id = 1; err_acc unchanged.
REQ-032 Scenario: both valid for 4 transactions, pointer starting at 0 -> grants alternate 0, 1, 0, 1.
REQ-033 Scenario: out_ready = 0 for 10 cycles in HOLD, a = b = 0x0100 -> out_sum = 0x00200 stable throughout, readies 0, then exactly one handshake.
REQ-034 Scenario: rst pulsed during CALC -> no out_valid, outputs 0, the next request is granted to requester 0.
